buffered_router: RTL and testbench

- Next-generation 9-port mesh router: NORTH, EAST, SOUTH, WEST, LOCAL, NE, NW, SE, SW.
- Each input port has a parametrised FIFO, so a blocked output no longer stalls the upstream link.
- Each output port has a round-robin arbiter and a registered output stage.
- Instantiated once per mesh node. Port index order comes from global_params: NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4, NE=5, NW=6, SE=7, SW=8.

---
 rtl/buffered_router.sv | 166 ++++++++++++++++
 tb/tb_buffered_router.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffered_router.sv
// 9-port mesh router: per-input FIFOs, sign-based XY/diagonal routing,
// per-output round-robin arbitration and a registered output stage.
module buffered_router #(
  parameter int unsigned X_COORD     = 0,
  parameter int unsigned Y_COORD     = 0,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [8:0]                            in_valid,
  output logic [8:0]                            in_ready,
  input  logic [9*DATA_WIDTH-1:0]               in_data,
  input  logic [9*COORD_WIDTH-1:0]              in_dest_x,
  input  logic [9*COORD_WIDTH-1:0]              in_dest_y,
  output logic [8:0]                            out_valid,
  input  logic [8:0]                            out_ready,
  output logic [9*DATA_WIDTH-1:0]               out_data,
  output logic [9*COORD_WIDTH-1:0]              out_dest_x,
  output logic [9*COORD_WIDTH-1:0]              out_dest_y,
  output logic [9*($clog2(FIFO_DEPTH)+1)-1:0]   fifo_level
);

  localparam int unsigned NP = 9;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = COORD_WIDTH;
  localparam int unsigned EW = DATA_WIDTH + 2 * COORD_WIDTH;

  localparam logic [3:0] DIR_N  = 4'd0;
  localparam logic [3:0] DIR_E  = 4'd1;
  localparam logic [3:0] DIR_S  = 4'd2;
  localparam logic [3:0] DIR_W  = 4'd3;
  localparam logic [3:0] DIR_L  = 4'd4;
  localparam logic [3:0] DIR_NE = 4'd5;
  localparam logic [3:0] DIR_NW = 4'd6;
  localparam logic [3:0] DIR_SE = 4'd7;
  localparam logic [3:0] DIR_SW = 4'd8;

  logic [EW-1:0]           mem [NP][FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr [NP];
  logic [PW-1:0]           rd_ptr [NP];
  logic [LW-1:0]           level [NP];
  logic [LW-1:0]           level_nxt [NP];
  logic [NP-1:0]           ready_q;
  logic [NP-1:0]           push;
  logic [NP-1:0]           pop;
  logic [NP-1:0]           load;
  logic [NP-1:0]           any_req;
  logic [EW-1:0]           head [NP];
  logic [3:0]              route [NP];
  logic [NP-1:0][NP-1:0]   req;
  logic [3:0]              gnt_idx [NP];
  logic [3:0]              cand;
  logic [3:0]              rr_ptr [NP];
  logic [NP-1:0]           valid_q;
  logic [EW-1:0]           out_q [NP];

  function automatic logic [3:0] route_of(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
    logic east, west, north, south;
    east  = dx > CW'(X_COORD);
    west  = dx < CW'(X_COORD);
    north = dy > CW'(Y_COORD);
    south = dy < CW'(Y_COORD);
    if (east)      return north ? DIR_NE : (south ? DIR_SE : DIR_E);
    else if (west) return north ? DIR_NW : (south ? DIR_SW : DIR_W);
    else           return north ? DIR_N  : (south ? DIR_S  : DIR_L);
  endfunction

  // Head entry and its routing direction, visible in the same cycle.
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      head[p]  = mem[p][rd_ptr[p]];
      route[p] = route_of(head[p][2*CW-1:CW], head[p][CW-1:0]);
    end
  end

  // Per-output round-robin: first requester at or after rr_ptr.
  always_comb begin
    pop     = '0;
    load    = '0;
    any_req = '0;
    cand    = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      gnt_idx[o] = '0;
      for (int unsigned i = 0; i < NP; i++)
        req[o][i] = (level[i] != '0) && (route[i] == 4'(o));
      for (int unsigned k = 0; k < NP; k++) begin
        cand = 4'((32'(rr_ptr[o]) + k) % NP);
        if (!any_req[o] && req[o][cand]) begin
          gnt_idx[o] = cand;
          any_req[o] = 1'b1;
        end
      end
      load[o] = any_req[o] && (!valid_q[o] || out_ready[o]);
      if (load[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      push[p]      = in_valid[p] & ready_q[p];
      level_nxt[p] = level[p] + LW'(push[p]) - LW'(pop[p]);
    end
  end

  // in_ready is registered from the next level, so it never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NP; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        level[p]  <= '0;
      end
      ready_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PW'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PW'(1);
        level[p]   <= level_nxt[p];
        ready_q[p] <= level_nxt[p] < LW'(FIFO_DEPTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NP; p++)
      if (push[p])
        mem[p][wr_ptr[p]] <= {in_data[p*DATA_WIDTH +: DATA_WIDTH],
                              in_dest_x[p*CW +: CW], in_dest_y[p*CW +: CW]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned o = 0; o < NP; o++) begin
        out_q[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NP; o++) begin
        if (load[o]) begin
          valid_q[o] <= 1'b1;
          out_q[o]   <= head[gnt_idx[o]];
          rr_ptr[o]  <= (gnt_idx[o] == 4'(NP - 1)) ? 4'd0 : gnt_idx[o] + 4'd1;
        end else if (out_ready[o]) begin
          valid_q[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NP; o++) begin
      out_data[o*DATA_WIDTH +: DATA_WIDTH] = out_q[o][EW-1 -: DATA_WIDTH];
      out_dest_x[o*CW +: CW]               = out_q[o][2*CW-1:CW];
      out_dest_y[o*CW +: CW]               = out_q[o][CW-1:0];
      fifo_level[o*LW +: LW]               = level[o];
    end
  end

  assign out_valid = valid_q;
  assign in_ready  = ready_q;

endmodule

// File: tb/tb_buffered_router.sv
// Randomised and directed bench for buffered_router against a queue-based
// transaction model of the node (node at (1,1), depth-4 FIFOs).
module tb_buffered_router;

  localparam int DW = 32;
  localparam int CW = 2;
  localparam int DEPTH = 4;
  localparam int LW = 3;
  localparam int MX = 1;
  localparam int MY = 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } flit_t;

  logic            clk;
  logic            rst;
  logic [8:0]      in_valid;
  logic [8:0]      in_ready;
  logic [9*DW-1:0] in_data;
  logic [9*CW-1:0] in_dest_x;
  logic [9*CW-1:0] in_dest_y;
  logic [8:0]      out_valid;
  logic [8:0]      out_ready;
  logic [9*DW-1:0] out_data;
  logic [9*CW-1:0] out_dest_x;
  logic [9*CW-1:0] out_dest_y;
  logic [9*LW-1:0] fifo_level;

  int tests;
  int fails;

  buffered_router #(
    .X_COORD(MX), .Y_COORD(MY), .DATA_WIDTH(DW), .COORD_WIDTH(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest_x(in_dest_x), .in_dest_y(in_dest_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest_x(out_dest_x), .out_dest_y(out_dest_y), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per input, one register per output.
  flit_t mq [9][$];
  bit    mov [9];
  flit_t moreg [9];
  int    mrr [9];
  bit    macc [9];
  bit    mready_en;

  function automatic int ref_dir(flit_t f);
    int sx, sy;
    sx = (int'(f.x) > MX) ? 1 : ((int'(f.x) < MX) ? -1 : 0);
    sy = (int'(f.y) > MY) ? 1 : ((int'(f.y) < MY) ? -1 : 0);
    case ((sx + 1) * 3 + (sy + 1))
      0: return 8;  // SW
      1: return 3;  // W
      2: return 6;  // NW
      3: return 2;  // S
      4: return 4;  // LOCAL
      5: return 0;  // N
      6: return 7;  // SE
      7: return 1;  // E
      default: return 5;  // NE
    endcase
  endfunction

  function automatic flit_t in_flit(int p);
    flit_t f;
    f.d = in_data[p*DW +: DW];
    f.x = in_dest_x[p*CW +: CW];
    f.y = in_dest_y[p*CW +: CW];
    return f;
  endfunction

  function automatic flit_t dut_out(int o);
    flit_t f;
    f.d = out_data[o*DW +: DW];
    f.x = out_dest_x[o*CW +: CW];
    f.y = out_dest_y[o*CW +: CW];
    return f;
  endfunction

  function automatic logic [LW-1:0] dut_level(int p);
    return fifo_level[p*LW +: LW];
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 9; p++) begin
      mq[p].delete();
      mov[p]  = 1'b0;
      mrr[p]  = 0;
      macc[p] = 1'b0;
    end
    mready_en = 1'b0;
  endtask

  task automatic model_edge();
    int g [9];
    int i;
    if (rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 9; p++)
      macc[p] = mready_en && in_valid[p] && (mq[p].size() < DEPTH);
    for (int o = 0; o < 9; o++) begin
      g[o] = -1;
      if (!mov[o] || out_ready[o])
        for (int k = 0; k < 9; k++) begin
          i = (mrr[o] + k) % 9;
          if (g[o] < 0 && mq[i].size() > 0 && ref_dir(mq[i][0]) == o) g[o] = i;
        end
    end
    for (int o = 0; o < 9; o++) begin
      if (g[o] >= 0) begin
        moreg[o] = mq[g[o]].pop_front();
        mov[o]   = 1'b1;
        mrr[o]   = (g[o] + 1) % 9;
      end else if (out_ready[o]) begin
        mov[o] = 1'b0;
      end
    end
    for (int p = 0; p < 9; p++)
      if (macc[p]) mq[p].push_back(in_flit(p));
    mready_en = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(int p, flit_t f);
    in_valid[p]          = 1'b1;
    in_data[p*DW +: DW]  = f.d;
    in_dest_x[p*CW +: CW] = f.x;
    in_dest_y[p*CW +: CW] = f.y;
  endtask

  // Offer a new tagged flit only when the previous one was taken (upstream holds).
  task automatic feed(int p, int x, int y);
    flit_t f;
    if (!in_valid[p] || macc[p]) begin
      f.d = {4'(p), 28'($urandom)};
      f.x = CW'(x);
      f.y = CW'(y);
      drive(p, f);
    end
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = '1;
    repeat (45) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_dest_x = '0; in_dest_y = '0;
    out_ready = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 9'h0 || fifo_level !== '0 || in_ready !== 9'h0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%h fifo_level=%h in_ready=%h, required 0/0/0",
               out_valid, fifo_level, in_ready);
    end
    tests++;
    if (out_data !== '0 || out_dest_x !== '0 || out_dest_y !== '0) begin
      fails++;
      $display("FAIL reset_fields: out_data=%h dest_x=%h dest_y=%h, required 0", out_data, out_dest_x, out_dest_y);
    end
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 9'h1FF) begin
      fails++;
      $display("FAIL ready_after_reset: in_ready=%h, required 1ff", in_ready);
    end
  endtask

  task automatic test_single_flit();
    flit_t f;
    f.d = $urandom; f.x = 2'd2; f.y = 2'd1;
    drive(4, f);
    step();
    tests++;
    if (dut_level(4) !== 3'd1 || out_valid !== 9'h0) begin
      fails++;
      $display("FAIL single_push: level=%0d out_valid=%h, required 1 / 000", dut_level(4), out_valid);
    end
    in_valid[4] = 1'b0;
    out_ready[1] = 1'b0;
    step();
    tests++;
    if (out_valid !== 9'h002 || dut_out(1) !== f || dut_level(4) !== 3'd0) begin
      fails++;
      $display("FAIL single_route: out_valid=%h flit=%h level=%0d, required 002 %h 0",
               out_valid, dut_out(1), dut_level(4), f);
    end
    step();
    tests++;
    if (out_valid !== 9'h002 || dut_out(1) !== f) begin
      fails++;
      $display("FAIL single_hold: out_valid=%h flit=%h, required 002 %h", out_valid, dut_out(1), f);
    end
    out_ready = '1;
    step();
    tests++;
    if (out_valid !== 9'h0) begin
      fails++;
      $display("FAIL single_release: out_valid=%h, required 000", out_valid);
    end
  endtask

  task automatic test_rotation();
    int ord [3];
    int src;
    ord[0] = 0; ord[1] = 1; ord[2] = 3;
    out_ready = '1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      feed(0, MX, MY); feed(1, MX, MY); feed(3, MX, MY);
      step();
      if (cyc >= 1) begin
        src = int'(out_data[4*DW + 28 +: 4]);
        tests++;
        if (out_valid[4] !== 1'b1 || src != ord[(cyc - 1) % 3] || dut_out(4) !== moreg[4]) begin
          fails++;
          $display("FAIL rotation cyc%0d: valid=%b src=%0d flit=%h, required 1 %0d %h",
                   cyc, out_valid[4], src, dut_out(4), ord[(cyc - 1) % 3], moreg[4]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    flit_t exp_f [6];
    flit_t got [$];
    int sent;
    sent = 0;
    for (int k = 0; k < 6; k++) begin
      exp_f[k].d = $urandom; exp_f[k].x = 2'd1; exp_f[k].y = 2'd0;
    end
    out_ready = '1;
    out_ready[2] = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (sent < 6) drive(0, exp_f[sent]); else in_valid[0] = 1'b0;
      step();
      if (in_valid[0] && macc[0]) sent++;
    end
    tests++;
    if (dut_level(0) !== 3'd4 || in_ready[0] !== 1'b0 || out_valid[2] !== 1'b1 || sent != 5) begin
      fails++;
      $display("FAIL backpressure_full: level=%0d in_ready=%b out_valid=%b accepted=%0d, required 4 0 1 5",
               dut_level(0), in_ready[0], out_valid[2], sent);
    end
    out_ready[2] = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 6; cyc++) begin
      if (out_valid[2] && out_ready[2]) got.push_back(dut_out(2));
      if (sent < 6) drive(0, exp_f[sent]); else in_valid[0] = 1'b0;
      step();
      if (in_valid[0] && macc[0]) sent++;
    end
    in_valid[0] = 1'b0;
    tests++;
    if (got.size() != 6) begin
      fails++;
      $display("FAIL backpressure_count: received %0d flits, required 6", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      tests++;
      if (got[k] !== exp_f[k]) begin
        fails++;
        $display("FAIL backpressure_order[%0d]: got %h, required %h", k, got[k], exp_f[k]);
      end
    end
  endtask

  task automatic test_diagonal();
    flit_t f [5];
    int dxs [5];
    int dys [5];
    int outs [5];
    dxs  = '{2, 0, 2, 0, 1};
    dys  = '{2, 2, 0, 0, 1};
    outs = '{5, 6, 7, 8, 4};
    out_ready = '1;
    for (int k = 0; k < 5; k++) begin
      f[k].d = $urandom; f[k].x = CW'(dxs[k]); f[k].y = CW'(dys[k]);
      drive(k, f[k]);
    end
    step();
    in_valid = '0;
    step();
    tests++;
    if (out_valid !== 9'h1F0) begin
      fails++;
      $display("FAIL diagonal_valid: out_valid=%h, required 1f0", out_valid);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (dut_out(outs[k]) !== f[k]) begin
        fails++;
        $display("FAIL diagonal_out%0d: got %h, required %h", outs[k], dut_out(outs[k]), f[k]);
      end
    end
  endtask

  task automatic test_full_drain();
    out_ready = '1;
    out_ready[2] = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      feed(3, 1, 0);
      step();
    end
    tests++;
    if (dut_level(3) !== 3'd4 || in_ready[3] !== 1'b0) begin
      fails++;
      $display("FAIL full_before_drain: level=%0d in_ready=%b, required 4 0", dut_level(3), in_ready[3]);
    end
    out_ready[2] = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      feed(3, 1, 0);
      step();
      tests++;
      if (dut_level(3) !== 3'd3 || in_ready[3] !== 1'b1 || 32'(dut_level(3)) != mq[3].size()) begin
        fails++;
        $display("FAIL full_drain cyc%0d: level=%0d in_ready=%b, required 3 1", cyc, dut_level(3), in_ready[3]);
      end
    end
    in_valid[3] = 1'b0;
  endtask

  task automatic test_reset_midstream();
    flit_t f0, f8;
    out_ready = '1;
    out_ready[4] = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      feed(5, MX, MY); feed(6, MX, MY); feed(7, MX, MY);
      step();
    end
    tests++;
    if (out_valid[4] !== 1'b1 || dut_level(5) == 3'd0 || dut_level(6) == 3'd0 || dut_level(7) == 3'd0) begin
      fails++;
      $display("FAIL midreset_setup: out_valid=%h fifo_level=%h, required LOCAL valid and 3 non-empty",
               out_valid, fifo_level);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 9'h0 || fifo_level !== '0 || in_ready !== 9'h0) begin
      fails++;
      $display("FAIL midreset_async: out_valid=%h fifo_level=%h in_ready=%h, required 0/0/0",
               out_valid, fifo_level, in_ready);
    end
    model_reset();
    in_valid = '0;
    out_ready = '1;
    step();
    rst = 1'b0;
    step();
    f0.d = $urandom; f0.x = 2'd1; f0.y = 2'd1;
    f8.d = $urandom; f8.x = 2'd1; f8.y = 2'd1;
    drive(0, f0);
    drive(8, f8);
    step();
    in_valid = '0;
    step();
    tests++;
    if (out_valid !== 9'h010 || dut_out(4) !== f0) begin
      fails++;
      $display("FAIL midreset_first: out_valid=%h flit=%h, required 010 %h", out_valid, dut_out(4), f0);
    end
    step();
    tests++;
    if (out_valid !== 9'h010 || dut_out(4) !== f8) begin
      fails++;
      $display("FAIL midreset_second: out_valid=%h flit=%h, required 010 %h", out_valid, dut_out(4), f8);
    end
  endtask

  task automatic test_random();
    flit_t f;
    logic [8:0] ev, er;
    logic [9*LW-1:0] el;
    logic [9*DW-1:0] ed;
    bit ok;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 9; p++) begin
        if (!in_valid[p] || macc[p]) begin
          if ($urandom_range(1, 0) == 1) begin
            f.d = $urandom; f.x = CW'($urandom_range(3, 0)); f.y = CW'($urandom_range(3, 0));
            drive(p, f);
          end else begin
            in_valid[p] = 1'b0;
          end
        end
        out_ready[p] = ($urandom_range(3, 0) != 0);
      end
      step();
      ok = 1'b1;
      ed = out_data;
      for (int o = 0; o < 9; o++) begin
        ev[o] = mov[o];
        er[o] = mready_en && (mq[o].size() < DEPTH);
        el[o*LW +: LW] = LW'(mq[o].size());
        if (mov[o]) begin
          ed[o*DW +: DW] = moreg[o].d;
          if (dut_out(o) !== moreg[o]) ok = 1'b0;
        end
      end
      tests++;
      if (!ok || out_valid !== ev || in_ready !== er || fifo_level !== el) begin
        fails++;
        $display("FAIL random cyc%0d: out_valid=%h in_ready=%h fifo_level=%h data=%h, required %h %h %h %h",
                 cyc, out_valid, in_ready, fifo_level, out_data, ev, er, el, ed);
      end
    end
    in_valid = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_flit();
    test_rotation();
    drain();
    test_backpressure();
    drain();
    test_diagonal();
    drain();
    test_full_drain();
    drain();
    test_reset_midstream();
    drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
